pipe_stage_skid: RTL and testbench

Parametrised pipeline stage register with a valid/ready handshake, a one-entry skid buffer, pipeline flush and a saturating back-pressure counter. It replaces plain enable-gated stage registers between pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) wherever a stage needs full throughput under back-pressure. The upstream ready does not depend combinationally on the downstream ready. Payload is an opaque packed vector; each stage instantiates it with the bit width of its stage struct.

---
 rtl/pipe_stage_skid.sv | 118 +++++++++++
 tb/tb_pipe_stage_skid.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, one-entry skid buffer,
// flush and a saturating back-pressure (stall) counter.
module pipe_stage_skid #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_q,  main_d;
    logic [DATA_W-1:0] skid_q,  skid_d;
    logic [CNT_W-1:0]  stall_q, stall_d;

    logic in_fire;
    logic out_fire;

    // Handshake outputs depend only on held state and flush, never on the peer's handshake.
    always_comb begin
        in_ready  = !flush && (state_q != ST_TWO);
        out_valid = !flush && (state_q != ST_EMPTY);
        in_fire   = in_valid && in_ready;
        out_fire  = out_valid && out_ready;
    end

    // Next-state, storage update and stall counting.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        stall_d = stall_q;

        if (out_valid && !out_ready && (stall_q != CNT_MAX)) begin
            stall_d = stall_q + CNT_W'(1);
        end

        if (flush) begin
            // Held entries are killed; data registers keep stale contents.
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d = ST_ONE;
                        main_d  = in_data;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        state_d = ST_TWO;
                        skid_d  = in_data;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // Upstream is blocked here, so only the drain side can move.
                    if (out_fire) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // State and data registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            stall_q <= stall_d;
        end
    end

    // Occupancy decode of the held-entry state.
    always_comb begin
        occupancy = 2'd0;
        case (state_q)
            ST_ONE:  occupancy = 2'd1;
            ST_TWO:  occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    assign out_data  = main_q;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Randomised, self-checking bench for pipe_stage_skid against a queue model.
module tb_pipe_stage_skid;

    localparam int unsigned DATA_W = 32;

    logic              clk;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              out_ready;

    logic              in_ready,  s_in_ready;
    logic              out_valid, s_out_valid;
    logic [DATA_W-1:0] out_data,  s_out_data;
    logic [1:0]        occupancy, s_occupancy;
    logic [15:0]       stall_cnt;
    logic [2:0]        s_stall_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: queue of accepted, not yet delivered payloads; stall cycle count.
    logic [DATA_W-1:0] q[$];
    int                stalls = 0;

    pipe_stage_skid #(.DATA_W(DATA_W), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    pipe_stage_skid #(.DATA_W(DATA_W), .CNT_W(3)) dut_sat (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
        .occupancy(s_occupancy), .stall_cnt(s_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, advance model at the edge.
    task automatic step(input logic iv, input logic [DATA_W-1:0] id, input logic ordy,
                        input logic fl, input logic probe);
        logic exp_ir, exp_ov, in_f, out_f;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        exp_ir = !fl && (q.size() < 2);
        exp_ov = !fl && (q.size() > 0);
        check("in_ready",   64'(in_ready),    64'(exp_ir));
        check("out_valid",  64'(out_valid),   64'(exp_ov));
        check("occupancy",  64'(occupancy),   64'(q.size()));
        check("stall_cnt",  64'(stall_cnt),   64'(stalls));
        check("sat_stall",  64'(s_stall_cnt), 64'((stalls > 7) ? 7 : stalls));
        check("sat_occ",    64'(s_occupancy), 64'(q.size()));
        if (exp_ov) begin
            check("out_data", 64'(out_data), 64'(q[0]));
        end
        if (probe) begin
            // Flipping the peer handshake must not move in_ready/out_valid.
            out_ready = !ordy;
            in_valid  = !iv;
            #1;
            check("ir_indep", 64'(in_ready),  64'(exp_ir));
            check("ov_indep", 64'(out_valid), 64'(exp_ov));
            out_ready = ordy;
            in_valid  = iv;
            #1;
        end
        in_f  = iv && exp_ir;
        out_f = exp_ov && ordy;
        if (exp_ov && !ordy) stalls++;
        if (fl) begin
            q.delete();
        end else begin
            if (out_f) void'(q.pop_front());
            if (in_f)  q.push_back(id);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; flush = 1'b1; in_valid = 1'b1;
        in_data = 32'hDEADBEEF; out_ready = 1'b0;

        // Reset held with flush and traffic asserted.
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("rst_in_ready",  64'(in_ready),  64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data",  64'(out_data),  64'(0));
        check("rst_occ",       64'(occupancy), 64'(0));
        check("rst_stall",     64'(stall_cnt), 64'(0));
        @(posedge clk);
        #1;

        // Streaming at full rate.
        for (int i = 1; i <= 8; i++) step(1'b1, DATA_W'(i), 1'b1, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("stream_stall", 64'(stall_cnt), 64'(0));

        // Back-pressure: 0xA, 0xB fill the stage, 0xC waits upstream.
        step(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b1, 32'hC, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hC, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'hC, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("bp_stall_sat", 64'(s_stall_cnt), 64'(7));

        // Flush with a full stage and a pending input.
        step(1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h22, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h33, 1'b0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Random traffic with occasional flush.
        for (int i = 0; i < 2000; i++) begin
            step(1'($urandom_range(0, 1)), DATA_W'($urandom()),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 99) < 5),
                 1'((i % 4) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
